// File: rtl/otp_pkg.sv
// Shared types and defaults for the OTP frame packer: FSM states, FIFO entry layout, checksum step.
package otp_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         PAYLOAD_LEN_DEF = 8;
  localparam int         FIFO_W          = 11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    HDR  = 3'd2,
    PAY  = 3'd3,
    CSUM = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] index;
    logic [7:0] data;
  } fifo_entry_t;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/otp_frame_packer_if.sv
// Ciphertext input stream and framed byte output stream of the packer.
interface otp_frame_packer_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_index;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_valid, in_data, in_index, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_index, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/otp_sync_fifo.sv
// Synchronous FIFO with full/empty/count; DEPTH must be a power of two so pointers wrap naturally.
module otp_sync_fifo
  import otp_pkg::*;
#(
  parameter int WIDTH = FIFO_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Storage array, written on push; contents need no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == (AW+1)'(0));
  assign o_count = r_count;

endmodule

// File: rtl/otp_frame_packer.sv
// Buffers ciphertext bytes and emits SYNC/HDR/payload/CSUM frames; flags pad-index sequence gaps.
module otp_frame_packer
  import otp_pkg::*;
#(
  parameter int         PAYLOAD_LEN = PAYLOAD_LEN_DEF,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  otp_frame_packer_if.slave   bus,
  output logic                seq_err,
  output logic [4:0]          frame_cnt
);

  localparam int               BW        = $clog2(PAYLOAD_LEN);
  localparam int               CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(PAYLOAD_LEN - 1);

  state_t              r_state;
  logic [BW-1:0]       r_beat;
  logic [7:0]          r_csum;
  logic [2:0]          r_exp_idx;
  logic [4:0]          r_frame_cnt;
  logic                r_seq_err;

  logic                w_push;
  logic                w_pop;
  logic                w_fire;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [FIFO_W-1:0]   w_fifo_q;
  fifo_entry_t         w_head;
  logic                w_out_valid;
  logic [7:0]          w_out_data;
  logic                w_out_last;

  assign w_push = bus.in_valid && !w_full;
  assign w_head = fifo_entry_t'(w_fifo_q);
  assign w_fire = w_out_valid && bus.out_ready;
  assign w_pop  = w_fire && (r_state == PAY);

  otp_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({bus.in_index, bus.in_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Output byte selection; every source is a register, so bytes hold while stalled.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = 8'h00;
    w_out_last  = 1'b0;
    case (r_state)
      IDLE: begin
        w_out_valid = 1'b0;
      end
      SYNC: begin
        w_out_valid = 1'b1;
        w_out_data  = SYNC_BYTE;
      end
      HDR: begin
        w_out_valid = 1'b1;
        w_out_data  = {r_frame_cnt, w_head.index};
      end
      PAY: begin
        w_out_valid = !w_empty;
        w_out_data  = w_head.data;
      end
      CSUM: begin
        w_out_valid = 1'b1;
        w_out_data  = r_csum;
        w_out_last  = 1'b1;
      end
      default: begin
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Frame FSM, checksum, beat counter, frame counter and sequence checker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= {BW{1'b0}};
      r_csum      <= 8'h00;
      r_exp_idx   <= 3'd0;
      r_frame_cnt <= 5'd0;
      r_seq_err   <= 1'b0;
    end else begin
      r_seq_err <= w_push && (bus.in_index != r_exp_idx);
      if (w_push) r_exp_idx <= bus.in_index + 3'd1;
      case (r_state)
        IDLE: if (w_count != CW'(0)) r_state <= SYNC;
        SYNC: if (w_fire) begin
          r_csum  <= 8'h00;
          r_state <= HDR;
        end
        HDR: if (w_fire) begin
          r_csum  <= w_out_data;
          r_beat  <= {BW{1'b0}};
          r_state <= PAY;
        end
        PAY: if (w_fire) begin
          r_csum <= csum_fold(r_csum, w_out_data);
          if (r_beat == LAST_BEAT) r_state <= CSUM;
          else                     r_beat  <= r_beat + BW'(1);
        end
        CSUM: if (w_fire) begin
          r_frame_cnt <= r_frame_cnt + 5'd1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_last  = w_out_last;
  assign seq_err       = r_seq_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_otp_frame_packer.sv
// Scoreboard bench for otp_frame_packer: expected frame bytes queued at stimulus time, checked by a monitor.
module tb_otp_frame_packer;

  logic       clk;
  logic       rst_n;
  logic       seq_err;
  logic [4:0] frame_cnt;

  otp_frame_packer_if bus();

  otp_frame_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .seq_err   (seq_err),
    .frame_cnt (frame_cnt)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pay[8];
  logic [2:0] pidx[8];
  logic [4:0] tb_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h with nothing expected at %0t", bus.out_data, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("out_byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
      end
    end
  end

  task automatic enq_frame(input int nbytes, input logic with_csum);
    logic [7:0] hdr;
    logic [7:0] cs;
    hdr = {tb_cnt, pidx[0]};
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, hdr});
    cs = hdr;
    for (int i = 0; i < nbytes; i++) begin
      exp_q.push_back({1'b0, pay[i]});
      cs = cs ^ pay[i];
    end
    if (with_csum) exp_q.push_back({1'b1, cs});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [7:0] d, input logic [2:0] ix, input logic exp_se);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_index = ix;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stuck 0 for byte 0x%0h", d);
    end else begin
      check("seq_err", {31'd0, seq_err}, {31'd0, exp_se});
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic finish_frame();
    wait_drain();
    tb_cnt = tb_cnt + 5'd1;
    check("frame_cnt", {27'd0, frame_cnt}, {27'd0, tb_cnt});
  endtask

  task automatic run_frame(input logic [7:0] base, input logic all_ff, input logic [2:0] idx0);
    for (int i = 0; i < 8; i++) begin
      pay[i]  = all_ff ? 8'hFF : base + 8'(i);
      pidx[i] = idx0 + 3'(i);
    end
    enq_frame(8, 1'b1);
    for (int i = 0; i < 8; i++) push(pay[i], pidx[i], 1'b0);
    finish_frame();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic a;
    logic [2:0] t4_idx[8];
    logic       t4_se[8];

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_index  = 3'd0;
    bus.out_ready = 1'b1;
    tb_cnt        = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_seq_err",   {31'd0, seq_err},       32'd0);
    check("rst_frame_cnt", {27'd0, frame_cnt},     32'd0);
    @(posedge clk);
    #1;

    // 1: data 01..08, idx 0..7 -> A5,00,01..08,08(last)
    run_frame(8'h01, 1'b0, 3'd0);
    // 2: all FF payload -> HDR 08, CSUM 08
    run_frame(8'h00, 1'b1, 3'd0);

    // 3: downstream stalled while six pushes are offered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pay[i]  = 8'h10 + 8'(i);
      pidx[i] = 3'(i);
    end
    enq_frame(8, 1'b1);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pay[acc];
      bus.in_index = pidx[acc];
      @(negedge clk);
      a = bus.in_ready;
      @(posedge clk);
      #1;
      if (a) acc++;
    end
    bus.in_valid = 1'b0;
    check("full_accepts", 32'(acc), 32'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("stall_valid",    {31'd0, bus.out_valid}, 32'd1);
      check("stall_data",     {24'd0, bus.out_data},  32'hA5);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = acc; i < 8; i++) push(pay[i], pidx[i], 1'b0);
    finish_frame();

    // 4: index gap 1->3 gives one seq_err pulse
    t4_idx = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    t4_se  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      pay[i]  = 8'h20 + 8'(i);
      pidx[i] = t4_idx[i];
    end
    enq_frame(8, 1'b1);
    for (int i = 0; i < 8; i++) push(pay[i], pidx[i], t4_se[i]);
    finish_frame();

    // 5: input gap mid-payload stalls output without aborting the frame
    for (int i = 0; i < 8; i++) begin
      pay[i]  = 8'h30 + 8'(i);
      pidx[i] = 3'd1 + 3'(i);
    end
    enq_frame(8, 1'b1);
    for (int i = 0; i < 3; i++) push(pay[i], pidx[i], 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 6) check("gap_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    for (int i = 3; i < 8; i++) push(pay[i], pidx[i], 1'b0);
    finish_frame();

    // 6: reset mid-payload abandons the frame
    for (int i = 0; i < 4; i++) begin
      pay[i]  = 8'h50 + 8'(i);
      pidx[i] = 3'd1 + 3'(i);
    end
    enq_frame(4, 1'b0);
    for (int i = 0; i < 4; i++) push(pay[i], pidx[i], 1'b0);
    wait_drain();
    @(negedge clk);
    check("midpay_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst2_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst2_frame_cnt", {27'd0, frame_cnt},     32'd0);
    tb_cnt = 5'd0;
    @(posedge clk);
    #1;
    run_frame(8'h40, 1'b0, 3'd0);

    // 7: frame counter wraps after 32 completed frames
    for (int f = 0; f < 31; f++) run_frame(8'(f * 8), 1'b0, 3'd0);
    run_frame(8'hC0, 1'b0, 3'd0);

    repeat (3) @(posedge clk);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
